dmem_wait_ctrl: RTL and testbench
=================================

Name: dmem_wait_ctrl

Overview:
- Wait-state data memory that consumes the single-cycle MIPS core's data port (address, write data, mem_read, mem_write).
- Replaces the zero-latency data memory with a fixed-latency word store.
- Provides a combinational stall so the core holds its PC and register write-back until the access completes.
- Sits directly downstream of the core's data-port outputs.

Parameters:
- ADDR_W, 10, word-address width; capacity is 2^ADDR_W 32-bit words.
- LATENCY, 3, access wait cycles, legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset; 0 resets the controller.
- adr  input  32  byte address from the core.
- wdata  input  32  store data.
- mem_read  input  1  load request, level.
- mem_write  input  1  store request, level.
- rdata  output  32  load data, registered.
- stall  output  1  core must not advance while 1.
- err  output  1  misaligned-access flag, valid in DONE.

Behaviour:
- State machine: IDLE, WAIT, DONE, 2-bit encoding.
- stall = (IDLE & (mem_read | mem_write)) | WAIT. It is combinational, so it rises in the same cycle the request appears.
- IDLE with a request at cycle t:
  - Capture adr, wdata and op (write if mem_write, else read). Both asserted is treated as write.
  - Load cnt = LATENCY and go to WAIT.
- WAIT:
  - Decrement cnt each edge.
  - On the edge where cnt==1, perform the access and go to DONE.
  - Write: array[adr[ADDR_W+1:2]] <= wdata.
  - Read: rdata <= array word.
  - WAIT occupies cycles t+1..t+LATENCY. DONE is cycle t+LATENCY+1. Stall is high for LATENCY+1 cycles.
- DONE:
  - stall=0 and rdata is valid; the core commits at the end of this cycle.
  - The request still visible in this cycle is ignored. Unconditionally return to IDLE.
- Port changes during WAIT are ignored; captured values are used.
- Address handling:
  - Bits above ADDR_W+1 are ignored, so addresses alias (wrap-around).
  - adr[1:0]!=0: no array write, rdata <= 0, err=1 in DONE only. err=0 in all other cycles.
- Back-to-back requests: IDLE always lasts at least one cycle between accesses. Every access therefore costs exactly LATENCY+2 cycles from first presentation.
- rdata holds its value until the next read completes; writes do not alter rdata.
- Reset (rst=0, any state, asynchronous):
  - state=IDLE, cnt=0, rdata=0, err=0.
  - stall follows the request inputs combinationally.
  - A pending write is dropped.
  - Array contents are not cleared.
- No request in IDLE: stall=0, no state change.

Optional Feature:
- Macro DMEM_FAST_READ_EN.
- Defined:
  - Reads bypass the wait state: rdata is driven combinationally from the array in IDLE, stall stays 0 and the state stays IDLE.
  - Misaligned reads return 0 with err=1 combinationally.
  - Writes keep full LATENCY behaviour.
- Undefined: all accesses behave as above.

Decomposition:
- Package dmem_pkg:
  - State encoding constants S_IDLE=0, S_WAIT=1, S_DONE=2.
  - WORD_W=32.
  - LATENCY default and its legality bound (15) for an elaboration check.
- Sub-module dmem_array:
  - 2^ADDR_W x 32 storage.
  - Synchronous write enable, asynchronous read.
  - Optional $readmemh init.
- dmem_wait_ctrl holds only the FSM, counter, capture registers and output registers.

Test Plan:
- Store: rst released; mem_write=1, adr=0x10, wdata=0x12345678 at t → stall=1 for t..t+3, DONE at t+4 with stall=0 and err=0; array word 4 = 0x12345678.
- Load-back: mem_read=1, adr=0x10 → stall for 4 cycles; rdata=0x12345678 in DONE; IDLE next cycle with stall=1 if the next request is present.
- Alias/misalign:
  - Write 0xCAFEF00D to 0x1010 (ADDR_W=10), then read 0x010 → 0xCAFEF00D.
  - Write to 0x13 → err=1 in DONE and array unchanged.
  - Read 0x13 → rdata=0.
- Reset mid-WAIT: drop rst during the second WAIT cycle of a write of 0xDEADBEEF to 0x20 → immediately state=IDLE, rdata=0, err=0; read 0x20 returns the prior value.
- Input churn: change adr and wdata every cycle during WAIT → only the values captured at t are written.
- With DMEM_FAST_READ_EN: read 0x10 → stall=0 and rdata=0x12345678 in the same cycle; a write still stalls LATENCY+1 cycles.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared constants and state encoding for the wait-state data memory.
package dmem_pkg;

    localparam int WORD_W      = 32;
    localparam int LATENCY_DEF = 3;
    localparam int LATENCY_MAX = 15;
    localparam int CNT_W       = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_array.sv
// Word store: 2^ADDR_W x 32, synchronous write, asynchronous read.
// Latency: write lands at the clock edge, read is combinational.
// Backpressure: none; the controller owns all sequencing.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WORD_W-1:0] i_wdat,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WORD_W-1:0] o_rdat
);

    logic [WORD_W-1:0] r_mem [2**ADDR_W];

    // Contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdat;
        end
    end

    assign o_rdat = r_mem[i_raddr];

endmodule

// File: rtl/dmem_wait_ctrl.sv
// Fixed-latency data memory controller for a single-cycle core; optional macro DMEM_FAST_READ_EN.
// Latency: request -> DONE in LATENCY+1 cycles, plus one mandatory IDLE cycle between accesses.
// Backpressure: combinational stall, high from request presentation through the last WAIT cycle.
module dmem_wait_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = LATENCY_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       adr,
    input  logic [31:0]       wdata,
    input  logic              mem_read,
    input  logic              mem_write,
    output logic [WORD_W-1:0] rdata,
    output logic              stall,
    output logic              err
);

    if (LATENCY < 1 || LATENCY > LATENCY_MAX) begin : g_bad_latency
        $error("dmem_wait_ctrl: LATENCY must be within 1..15");
    end

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [ADDR_W-1:0]   r_widx;
    logic [1:0]          r_boff;
    logic [WORD_W-1:0]   r_wdata;
    logic                r_wr;
    logic [WORD_W-1:0]   r_rdata;
    logic                r_err;

    logic                w_req;
    logic                w_last;
    logic                w_mis;
    logic                w_we;
    logic [ADDR_W-1:0]   w_raddr;
    logic [WORD_W-1:0]   w_rd_dat;
    logic                w_unused;

    assign w_unused = ^adr[31:ADDR_W+2];

`ifdef DMEM_FAST_READ_EN
    logic w_fast;

    // Only stores enter the wait sequence; loads are served straight from the array in IDLE.
    assign w_req   = mem_write;
    assign w_fast  = (r_state == S_IDLE) && mem_read && !mem_write;
    assign w_raddr = (r_state == S_IDLE) ? adr[ADDR_W+1:2] : r_widx;
    assign rdata   = w_fast ? ((adr[1:0] != 2'b00) ? '0 : w_rd_dat) : r_rdata;
    assign err     = w_fast ? (adr[1:0] != 2'b00) : r_err;
`else
    assign w_req   = mem_read | mem_write;
    assign w_raddr = r_widx;
    assign rdata   = r_rdata;
    assign err     = r_err;
`endif

    assign stall  = ((r_state == S_IDLE) && w_req) || (r_state == S_WAIT);
    assign w_last = (r_state == S_WAIT) && (r_cnt == CNT_W'(1));
    assign w_mis  = (r_boff != 2'b00);
    assign w_we   = w_last && r_wr && !w_mis;

    dmem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_widx),
        .i_wdat  (r_wdata),
        .i_raddr (w_raddr),
        .o_rdat  (w_rd_dat)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_widx  <= '0;
            r_boff  <= '0;
            r_wdata <= '0;
            r_wr    <= 1'b0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_widx  <= adr[ADDR_W+1:2];
                        r_boff  <= adr[1:0];
                        r_wdata <= wdata;
                        r_wr    <= mem_write;
                        r_cnt   <= CNT_W'(LATENCY);
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (w_last) begin
                        r_state <= S_DONE;
                        r_err   <= w_mis;
                        if (!r_wr) begin
                            r_rdata <= w_mis ? '0 : w_rd_dat;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_wait_ctrl.sv
// Directed bench for dmem_wait_ctrl (default build, LATENCY=3, ADDR_W=10).
module tb_dmem_wait_ctrl;
    import dmem_pkg::*;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] adr;
    logic [31:0] wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] rdata;
    logic        stall;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dmem_wait_ctrl #(
        .ADDR_W  (10),
        .LATENCY (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .adr       (adr),
        .wdata     (wdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .rdata     (rdata),
        .stall     (stall),
        .err       (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete access; the request is held through DONE to show it is ignored there.
    task automatic access(input string tag, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic churn,
                          input logic exp_err, input logic [31:0] exp_rd);
        @(negedge clk);
        mem_write = wr;
        mem_read  = !wr;
        adr       = a;
        wdata     = d;
        #1;
        chk({tag, "_stall_req"}, 32'(stall), 32'd1);
        for (int i = 1; i <= LAT; i++) begin
            @(negedge clk);
            if (churn) begin
                adr   = $urandom;
                wdata = $urandom;
            end
            #1;
            chk({tag, "_stall_wait"}, 32'(stall), 32'd1);
            chk({tag, "_err_wait"}, 32'(err), 32'd0);
        end
        @(negedge clk);
        #1;
        chk({tag, "_stall_done"}, 32'(stall), 32'd0);
        chk({tag, "_err_done"}, 32'(err), 32'(exp_err));
        chk({tag, "_rdata_done"}, rdata, exp_rd);
        mem_write = 1'b0;
        mem_read  = 1'b0;
    endtask

    initial begin
        rst       = 1'b0;
        adr       = '0;
        wdata     = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        #2;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("idle_stall", 32'(stall), 32'd0);

        access("store", 1'b1, 32'h10, 32'h1234_5678, 1'b0, 1'b0, 32'h0);
        chk("store_array_w4", dut.u_array.r_mem[4], 32'h1234_5678);
        access("load", 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h1234_5678);

        access("alias_wr", 1'b1, 32'h1010, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h1234_5678);
        access("alias_rd", 1'b0, 32'h010, 32'h0, 1'b0, 1'b0, 32'hCAFE_F00D);

        access("mis_wr", 1'b1, 32'h13, 32'hBAD0_BAD0, 1'b0, 1'b1, 32'hCAFE_F00D);
        chk("mis_wr_array", dut.u_array.r_mem[4], 32'hCAFE_F00D);
        access("mis_rd", 1'b0, 32'h13, 32'h0, 1'b0, 1'b1, 32'h0);
        access("post_mis_rd", 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'hCAFE_F00D);

        access("churn_wr", 1'b1, 32'h24, 32'h0BAD_CAFE, 1'b1, 1'b0, 32'hCAFE_F00D);
        access("churn_rd", 1'b0, 32'h24, 32'h0, 1'b0, 1'b0, 32'h0BAD_CAFE);

        access("seed_wr", 1'b1, 32'h20, 32'h5A5A_5A5A, 1'b0, 1'b0, 32'h0BAD_CAFE);
        access("seed_rd", 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h5A5A_5A5A);

        @(negedge clk);
        mem_write = 1'b1;
        adr       = 32'h20;
        wdata     = 32'hDEAD_BEEF;
        #1;
        chk("rstw_stall_req", 32'(stall), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstw_state", 32'(dut.r_state), 32'(S_IDLE));
        chk("rstw_rdata", rdata, 32'd0);
        chk("rstw_err", 32'(err), 32'd0);
        chk("rstw_stall_follow", 32'(stall), 32'd1);
        mem_write = 1'b0;
        #1;
        chk("rstw_stall_drop", 32'(stall), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        access("rstw_rd", 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h5A5A_5A5A);

        @(negedge clk);
        #1;
        chk("final_idle_stall", 32'(stall), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
